// File: rtl/tmr0_wdt_ctrl.sv
// TMR0 clock-source, T0CKI sync, shared prescaler and sleep tracking for the PIC16F54 core.
// Define TMR0_WDT_CTRL_WDT_EN to build the watchdog; otherwise wdtmr is tied low.
module tmr0_wdt_ctrl #(
    parameter int WDT_BASE_W  = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] option_in,
    input  logic       t0cki,
    input  logic       tmr0_wr,
    input  logic       clrwdt,
    input  logic       sleep,
    output logic       tmr0_inc,
    output logic       wdtmr,
    output logic       asleep,
    output logic [7:0] psc_cnt
);

    logic                   t0cs_s;
    logic                   t0se_s;
    logic                   psa_s;
    logic [2:0]             ps_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   sync_last_s;
    logic                   ext_evt_s;
    logic                   src_evt_s;
    logic                   psa_chg_s;
    logic [7:0]             tc_tmr_s;
    logic                   psa_shadow_r;
    logic [7:0]             psc_cnt_r;
    logic [7:0]             psc_cnt_s;
    logic                   tmr0_inc_r;
    logic                   tmr0_inc_s;
    logic                   wdtmr_r;
    logic                   wdtmr_s;
    logic                   asleep_r;
    logic                   asleep_s;
    logic                   unused_s;

    assign t0cs_s      = option_in[5];
    assign t0se_s      = option_in[4];
    assign psa_s       = option_in[3];
    assign ps_s        = option_in[2:0];
    assign sync_last_s = sync_r[SYNC_STAGES-1];
    assign ext_evt_s   = t0se_s ? (hist_r & ~sync_last_s) : (~hist_r & sync_last_s);
    assign src_evt_s   = t0cs_s ? ext_evt_s : ~asleep_r;
    assign psa_chg_s   = psa_s ^ psa_shadow_r;
    // Terminal count 2^(PS+1)-1 without an overflowing shift at PS=7
    assign tc_tmr_s    = 8'hFF >> (3'd7 - ps_s);

`ifdef TMR0_WDT_CTRL_WDT_EN
    logic [WDT_BASE_W-1:0] wdt_base_r;
    logic [WDT_BASE_W-1:0] wdt_base_s;
    logic [7:0]            tc_wdt_s;
    logic                  base_ovf_s;
    logic                  wdt_clr_s;
    logic                  wdt_hit_s;
    logic                  timeout_s;

    assign tc_wdt_s   = 8'h7F >> (3'd7 - ps_s);
    assign base_ovf_s = &wdt_base_r;
    assign wdt_clr_s  = clrwdt | sleep;
    assign wdt_hit_s  = psa_s ? (psc_cnt_r == tc_wdt_s) : 1'b1;
    // Clears and a PSA switch both outrank a timeout in the same cycle
    assign timeout_s  = base_ovf_s & wdt_hit_s & ~wdt_clr_s & ~psa_chg_s;
    assign unused_s   = ^option_in[7:6];

    // WDT base counter and sleep flag next state
    always_comb begin
        wdt_base_s = wdt_base_r + WDT_BASE_W'(1'b1);
        wdtmr_s    = timeout_s;
        if (wdt_clr_s || timeout_s) begin
            wdt_base_s = {WDT_BASE_W{1'b0}};
        end else begin
            wdt_base_s = wdt_base_r + WDT_BASE_W'(1'b1);
        end
        if (sleep) begin
            asleep_s = 1'b1;
        end else if (timeout_s) begin
            asleep_s = 1'b0;
        end else begin
            asleep_s = asleep_r;
        end
    end

    // WDT base counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_base_r <= {WDT_BASE_W{1'b0}};
        end else begin
            wdt_base_r <= wdt_base_s;
        end
    end
`else
    logic [WDT_BASE_W-1:0] wdt_unused_s;

    assign wdt_unused_s = {WDT_BASE_W{1'b0}};
    assign unused_s     = ^{option_in[7:6], clrwdt, wdt_unused_s};

    // Without the watchdog only reset can wake the core
    always_comb begin
        wdtmr_s = 1'b0;
        if (sleep) begin
            asleep_s = 1'b1;
        end else begin
            asleep_s = asleep_r;
        end
    end
`endif

    // Prescaler and TMR0 increment next state
    always_comb begin
        psc_cnt_s  = psc_cnt_r;
        tmr0_inc_s = 1'b0;
        if (psa_chg_s) begin
            psc_cnt_s = 8'd0;
        end else if (!psa_s) begin
            if (tmr0_wr) begin
                psc_cnt_s = 8'd0;
            end else if (src_evt_s) begin
                if (psc_cnt_r == tc_tmr_s) begin
                    psc_cnt_s  = 8'd0;
                    tmr0_inc_s = 1'b1;
                end else begin
                    psc_cnt_s = psc_cnt_r + 8'd1;
                end
            end else begin
                psc_cnt_s = psc_cnt_r;
            end
        end else begin
            tmr0_inc_s = src_evt_s;
`ifdef TMR0_WDT_CTRL_WDT_EN
            if (wdt_clr_s || timeout_s) begin
                psc_cnt_s = 8'd0;
            end else if (base_ovf_s) begin
                psc_cnt_s = psc_cnt_r + 8'd1;
            end else begin
                psc_cnt_s = psc_cnt_r;
            end
`else
            psc_cnt_s = 8'd0;
`endif
        end
    end

    // T0CKI synchroniser and edge-history flop
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], t0cki};
            hist_r <= sync_last_s;
        end
    end

    // Prescaler, PSA shadow and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            psc_cnt_r    <= 8'd0;
            psa_shadow_r <= 1'b0;
            tmr0_inc_r   <= 1'b0;
            wdtmr_r      <= 1'b0;
            asleep_r     <= 1'b0;
        end else begin
            psc_cnt_r    <= psc_cnt_s;
            psa_shadow_r <= psa_s;
            tmr0_inc_r   <= tmr0_inc_s;
            wdtmr_r      <= wdtmr_s;
            asleep_r     <= asleep_s;
        end
    end

    assign tmr0_inc = tmr0_inc_r;
    assign wdtmr    = wdtmr_r;
    assign asleep   = asleep_r;
    assign psc_cnt  = psc_cnt_r;

endmodule

// File: doc/tmr0_wdt_ctrl.md
Name: tmr0_wdt_ctrl

Overview:
- Timing controller for the PIC16F54 core. Generates the core's `tmr0_inc` and `wdtmr` pulses from the OPTION register value (`option_out`).
- Owns the TMR0 clock-source select, the T0CKI synchroniser and edge selection, the shared 8-bit prescaler and its assignment (PSA), the WDT base counter, and sleep/wake tracking.
- Sits beside the core: OPTION in; `tmr0_inc`/`wdtmr` out.

Parameters:
- WDT_BASE_W, 10: width of the WDT base counter. Base WDT period is 2^WDT_BASE_W clk cycles.
- SYNC_STAGES, 2: number of flops in the T0CKI synchroniser (minimum 2).

Ports:
- clk  in  1  core clock; one clk = one instruction cycle.
- rst  in  1  synchronous, active-high reset.
- option_in  in  8  OPTION register: [5] T0CS, [4] T0SE, [3] PSA, [2:0] PS.
- t0cki  in  1  external TMR0 clock pin, asynchronous.
- tmr0_wr  in  1  pulse: core writes TMR0 this cycle.
- clrwdt  in  1  pulse: CLRWDT executed.
- sleep  in  1  pulse: SLEEP executed.
- tmr0_inc  out  1  one-cycle TMR0 increment pulse, registered.
- wdtmr  out  1  one-cycle WDT timeout pulse, registered.
- asleep  out  1  core-in-sleep flag.
- psc_cnt  out  8  current prescaler value (observability).

Behaviour:
- Reset (rst=1 at a clk edge): synchroniser, edge-history flop, prescaler, WDT base, PSA shadow, `tmr0_inc`, `wdtmr` and `asleep` all go to 0.
- T0CKI path: SYNC_STAGES-flop synchroniser, then compare last stage with a history flop.
  - T0SE=0: event on 0->1.
  - T0SE=1: event on 1->0.
  - First registered effect appears SYNC_STAGES+1 edges after the first edge that samples the new `t0cki` level.
- TMR0 source event:
  - T0CS=0: every cycle with `asleep`=0.
  - T0CS=1: every T0CKI edge event, counted even while asleep.
- PSA=0 (prescaler on TMR0):
  - On a source event: if `psc_cnt` == 2^(PS+1)-1, set `psc_cnt` to 0 and pulse `tmr0_inc` next cycle; else increment `psc_cnt`. Ratio is 1:2^(PS+1).
  - WDT times out on each base overflow.
- PSA=1 (prescaler on WDT):
  - `tmr0_inc` pulses the cycle after every source event (1:1).
  - On a base overflow: if `psc_cnt` == 2^PS-1, clear it and time out; else increment. Ratio is 1:2^PS.
- WDT base counter: increments every cycle, asleep or not. Overflow event when it equals 2^WDT_BASE_W-1; it then wraps to 0.
- Timeout:
  - `wdtmr`=1 for exactly one cycle.
  - `asleep` cleared, WDT base cleared.
  - Prescaler cleared if PSA=1.
- `clrwdt` or `sleep` pulse: clear WDT base; clear prescaler if PSA=1. `sleep` additionally sets `asleep`=1 next cycle.
- `tmr0_wr` with PSA=0: clear prescaler; no `tmr0_inc` may result from that cycle's event.
- PSA change (`option_in[3]` differs from its shadow flop): clear prescaler this cycle and update the shadow. No `tmr0_inc` or timeout is produced in that cycle.
- PS change with PSA unchanged: prescaler is not cleared. The new terminal count applies from the next event. If `psc_cnt` is already above the new terminal count, it counts up to 255, wraps to 0, then proceeds normally.
- Priority within a cycle, highest first: rst > clear (`clrwdt`/`sleep`/`tmr0_wr`/PSA change) > timeout > increment.
  - `clrwdt` coincident with a would-be timeout: no `wdtmr` pulse.
  - `sleep` coincident with a timeout: no pulse, `asleep`=1.
- `sleep` while already asleep: restarts the WDT (clears base and, if PSA=1, the prescaler); `asleep` stays 1.

Optional Feature:
- Macro: TMR0_WDT_CTRL_WDT_EN.
- Defined: full WDT behaviour as above.
- Undefined:
  - WDT base counter and timeout logic removed; `wdtmr` tied to 0.
  - `asleep` is left only by rst.
  - PSA=1 means TMR0 is unprescaled (1:1) and the prescaler holds 0.

Test Plan:
- rst, then option_in=0x00 (T0CS=0, PSA=0, PS=0), idle 8 cycles -> `tmr0_inc` pulses on cycles 2, 4, 6, 8; `psc_cnt` alternates 1, 0; `wdtmr`=0.
- option_in=0x30 (T0CS=1, T0SE=1, PSA=0, PS=0), SYNC_STAGES=2, drive four falling edges on `t0cki` at 10-cycle spacing:
  - each pulse appears 3 edges after sampling;
  - `tmr0_inc` pulses follow the 2nd and 4th falling edges only;
  - rising edges produce no pulses.
- WDT_BASE_W=4, option_in=0x0A (PSA=1, PS=2), no `clrwdt` -> `wdtmr` pulses 64 cycles after reset release, then every 64 cycles; `tmr0_inc` pulses every cycle.
- WDT_BASE_W=4, PSA=0, `clrwdt` every 10 cycles for 100 cycles -> no `wdtmr`. Then `clrwdt` on the exact cycle of a would-be timeout -> still no pulse.
- WDT_BASE_W=4, option_in=0x08, pulse `sleep` -> `asleep`=1 next cycle; `tmr0_inc` stops (T0CS=0); `wdtmr` pulses 16 cycles after `sleep`; `asleep` returns to 0.
- PSA=0, PS=7, `psc_cnt`=0x50, pulse `tmr0_wr` concurrent with a source event -> `psc_cnt`=0, no `tmr0_inc`. Then toggle PSA -> `psc_cnt`=0 again.
